board_io_ctrl: RTL and testbench

Parametrised board I/O controller between the FPGA pins and the SimpleCPU ports. It synchronises and debounces N push buttons, then presents them as levels, single-cycle press/release pulses and sticky press flags. It drives M user LEDs from a selectable byte lane of a 32-bit CPU output word, with PWM brightness control and configurable pin polarity.

---
 rtl/board_io_ctrl.sv | 107 ++++++++++
 tb/tb_board_io_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: debounced push-button inputs and PWM-dimmed, lane-selected LED outputs for SimpleCPU
// Ports: clk/reset (sync, active-high); pb_raw -> pb_level/pb_press/pb_release/pb_latched (pb_clear clears latched);
//        led_word/led_lane/led_brightness -> led_pin (polarity per LED_ACTIVE_LOW).
module board_io_ctrl #(
  parameter int PB_WIDTH        = 4,
  parameter int PB_ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LED_WIDTH       = 8,
  parameter int LED_ACTIVE_LOW  = 1,
  parameter int PWM_BITS        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PB_WIDTH-1:0]  pb_raw,
  output logic [PB_WIDTH-1:0]  pb_level,
  output logic [PB_WIDTH-1:0]  pb_press,
  output logic [PB_WIDTH-1:0]  pb_release,
  output logic [PB_WIDTH-1:0]  pb_latched,
  input  logic [PB_WIDTH-1:0]  pb_clear,
  input  logic [31:0]          led_word,
  input  logic [1:0]           led_lane,
  input  logic [PWM_BITS-1:0]  led_brightness,
  output logic [LED_WIDTH-1:0] led_pin
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic {STABLE, COUNTING} db_state_e;
  logic [PB_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PB_WIDTH-1:0] level_q, level_d, press_q, press_d, release_q, release_d, latched_q, latched_d;
  db_state_e state_q [PB_WIDTH];
  db_state_e state_d [PB_WIDTH];
  logic [PB_WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] slice_q, slice_d, on_q, on_d;
  logic [PWM_BITS-1:0]  bright_q, bright_d, pwm_cnt_q, pwm_cnt_d;
  logic                 pwm_en;
  always_comb begin
    sync1_d   = PB_ACTIVE_LOW != 0 ? ~pb_raw : pb_raw;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < PB_WIDTH; i++) begin
      if (state_q[i] == STABLE) begin
        if (sync2_q[i] != level_q[i]) begin
          state_d[i] = COUNTING;
          cnt_d[i]   = CW'(1);
        end
      end else if (sync2_q[i] == level_q[i]) begin
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        // accept: the pulses are registered alongside the level so all three change together
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
        state_d[i]   = STABLE;
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // set has priority over clear
    latched_d = press_q | (latched_q & ~pb_clear);
  end
  always_comb begin
    slice_d   = led_word[{led_lane, 3'b000} +: LED_WIDTH];
    bright_d  = led_brightness;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_en    = (&bright_q) | (pwm_cnt_q < bright_q);
    on_d      = slice_q & {LED_WIDTH{pwm_en}};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      latched_q <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < PB_WIDTH; i++) state_q[i] <= STABLE;
      slice_q   <= '0;
      bright_q  <= '0;
      pwm_cnt_q <= '0;
      on_q      <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      latched_q <= latched_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      slice_q   <= slice_d;
      bright_q  <= bright_d;
      pwm_cnt_q <= pwm_cnt_d;
      on_q      <= on_d;
    end
  end
  assign pb_level   = level_q;
  assign pb_press   = press_q;
  assign pb_release = release_q;
  assign pb_latched = latched_q;
  assign led_pin    = LED_ACTIVE_LOW != 0 ? ~on_q : on_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed scoreboard bench for board_io_ctrl
module tb_board_io_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pb_raw = 4'hF;
  logic [3:0] pb_clear = 4'h0;
  logic [3:0] pb_level, pb_press, pb_release, pb_latched;
  logic [31:0] led_word = 32'h0;
  logic [1:0]  led_lane = 2'd0;
  logic [3:0]  led_brightness = 4'd0;
  logic [7:0]  led_pin;
  int n_checks = 0;
  int n_errors = 0;
  typedef struct {int lat; logic [3:0] press; logic [3:0] rel;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  board_io_ctrl #(
    .PB_WIDTH(4), .PB_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(16),
    .LED_WIDTH(8), .LED_ACTIVE_LOW(1), .PWM_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .pb_raw(pb_raw), .pb_level(pb_level),
    .pb_press(pb_press), .pb_release(pb_release), .pb_latched(pb_latched),
    .pb_clear(pb_clear), .led_word(led_word), .led_lane(led_lane),
    .led_brightness(led_brightness), .led_pin(led_pin)
  );
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(int lat, logic [3:0] p, logic [3:0] r);
    exp_t e;
    e.lat = lat; e.press = p; e.rel = r;
    sb.push_back(e);
  endtask
  task automatic wait_event(string tag, int budget);
    exp_t e;
    int lat = 0;
    e = sb.pop_front();
    do begin
      step();
      lat++;
    end while (lat < budget && (pb_press | pb_release) == 4'h0);
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_press"}, pb_press, e.press);
    chk({tag, "_rel"}, pb_release, e.rel);
  endtask
  initial begin
    logic [3:0] seen;
    int lit, off, other;
    step(3);
    chk("rst_level", pb_level, 0);
    chk("rst_press", pb_press, 0);
    chk("rst_release", pb_release, 0);
    chk("rst_latched", pb_latched, 0);
    chk("rst_led", led_pin, 8'hFF);
    chk("rst_pwm", dut.pwm_cnt_q, 0);
    reset = 1'b0;
    step(2);
    pb_raw = 4'hE;
    push(18, 4'b0001, 4'b0000);
    wait_event("press0", 40);
    chk("press0_level", pb_level, 4'b0001);
    step();
    chk("press0_oneshot", pb_press, 0);
    chk("press0_latched", pb_latched, 4'b0001);
    pb_raw = 4'hF;
    push(18, 4'b0000, 4'b0001);
    wait_event("rel0", 40);
    chk("rel0_level", pb_level, 0);
    step();
    chk("rel0_oneshot", pb_release, 0);
    seen = 4'h0;
    for (int i = 0; i < 12; i++) begin
      pb_raw[1] = ~pb_raw[1];
      for (int j = 0; j < 5; j++) begin
        step();
        seen |= pb_press | pb_release;
      end
    end
    chk("bounce_quiet", seen, 0);
    chk("bounce_level", pb_level, 0);
    pb_raw[1] = 1'b0;
    push(18, 4'b0010, 4'b0000);
    wait_event("bounce_press1", 40);
    pb_raw = 4'hF;
    push(18, 4'b0000, 4'b0010);
    wait_event("rel1", 40);
    step();
    pb_raw[2] = 1'b0;
    push(18, 4'b0100, 4'b0000);
    wait_event("press2", 40);
    pb_clear = 4'b0100;
    step();
    chk("set_wins", pb_latched, 4'b0111);
    step();
    chk("clear_later", pb_latched, 4'b0011);
    pb_clear = 4'h0;
    pb_raw = 4'hF;
    push(18, 4'b0000, 4'b0100);
    wait_event("rel2", 40);
    led_word = 32'h00A50000;
    led_lane = 2'd2;
    led_brightness = 4'd15;
    step(2);
    chk("led_full", led_pin, 8'h5A);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (led_pin == 8'h5A) lit++;
    end
    chk("led_full_duty", lit, 16);
    led_brightness = 4'd4;
    step(2);
    lit = 0; off = 0; other = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (led_pin == 8'h5A) lit++;
      else if (led_pin == 8'hFF) off++;
      else other++;
    end
    chk("pwm4_lit", lit, 8);
    chk("pwm4_off", off, 24);
    chk("pwm4_other", other, 0);
    led_brightness = 4'd0;
    step(2);
    off = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (led_pin == 8'hFF) off++;
    end
    chk("pwm0_off", off, 16);
    led_word = 32'h00003C00;
    led_lane = 2'd1;
    led_brightness = 4'd15;
    step();
    chk("lane_latency", led_pin, 8'hFF);
    step();
    chk("lane1", led_pin, 8'hC3);
    pb_raw = 4'h7;
    seen = 4'h0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= pb_press | pb_release;
    end
    chk("middb_quiet", seen, 0);
    chk("middb_level", pb_level, 0);
    reset = 1'b1;
    step();
    chk("middb_rst_latched", pb_latched, 0);
    reset = 1'b0;
    push(18, 4'b1000, 4'b0000);
    wait_event("middb_press3", 40);
    chk("middb_level3", pb_level, 4'b1000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
